// File: rtl/div_issue_ctrl.sv
// Issue/collect controller around the 8-by-4 restoring array divider: queues operand
// pairs, screens divide-by-zero and overflow, drives the array, waits, and returns tagged results.
module div_issue_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [3:0]       in_y,
  output logic [7:0]       arr_x,
  output logic [3:0]       arr_y,
  output logic [3:0]       arr_bin,
  input  logic [3:0]       arr_q,
  input  logic [3:0]       arr_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_q,
  output logic [3:0]       out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 12 + TAG_W;
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]      PTR_ONE     = (AW + 1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE     = TAG_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------- input FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [TAG_W-1:0] tag_cnt_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [EW-1:0] head;
  logic [7:0]    head_x;
  logic [3:0]    head_y;
  logic [TAG_W-1:0] head_tag;
  logic          head_dbz, head_ovf;

  state_t state_q, state_d;

  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_empty = (wptr_q == rptr_q);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q[AW-1:0]] <= {in_x, in_y, tag_cnt_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (push) begin
        wptr_q    <= wptr_q + PTR_ONE;
        tag_cnt_q <= tag_cnt_q + TAG_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  assign head     = fifo_mem[rptr_q[AW-1:0]];
  assign head_x   = head[EW-1 -: 8];
  assign head_y   = head[TAG_W +: 4];
  assign head_tag = head[TAG_W-1:0];
  assign head_dbz = (head_y == 4'd0);
  assign head_ovf = (head_x[7:4] >= head_y);

  // ---------------------------------------------------------------- issue FSM
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       arr_x_q, arr_x_d;
  logic [3:0]       arr_y_q, arr_y_d;
  logic             pend_dbz_q, pend_dbz_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic [3:0]       cur_xlo_q, cur_xlo_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic             ovalid_q, ovalid_d;
  logic [3:0]       quot_q, quot_d;
  logic [3:0]       rem_q, rem_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // Screened pairs also pass through SETTLE with a zero count, so their result
  // lands one edge after the pop while the array inputs stay untouched.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arr_x_d    = arr_x_q;
    arr_y_d    = arr_y_q;
    pend_dbz_d = pend_dbz_q;
    pend_ovf_d = pend_ovf_q;
    cur_xlo_d  = cur_xlo_q;
    cur_tag_d  = cur_tag_q;
    ovalid_d   = ovalid_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    otag_d     = otag_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d    = S_SETTLE;
          cur_xlo_d  = head_x[3:0];
          cur_tag_d  = head_tag;
          pend_dbz_d = head_dbz;
          pend_ovf_d = !head_dbz && head_ovf;
          if (!head_dbz && !head_ovf) begin
            arr_x_d = head_x;
            arr_y_d = head_y;
            cnt_d   = SETTLE_INIT;
          end else begin
            cnt_d   = 4'd0;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_HOLD;
          ovalid_d = 1'b1;
          otag_d   = cur_tag_q;
          if (pend_dbz_q) begin
            quot_d = 4'hF;
            rem_d  = cur_xlo_q;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
          end else if (pend_ovf_q) begin
            quot_d = 4'hF;
            rem_d  = 4'hF;
            dbz_d  = 1'b0;
            ovf_d  = 1'b1;
          end else begin
            quot_d = arr_q;
            rem_d  = arr_r;
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      arr_x_q    <= '0;
      arr_y_q    <= '0;
      pend_dbz_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      cur_xlo_q  <= '0;
      cur_tag_q  <= '0;
      ovalid_q   <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      otag_q     <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arr_x_q    <= arr_x_d;
      arr_y_q    <= arr_y_d;
      pend_dbz_q <= pend_dbz_d;
      pend_ovf_q <= pend_ovf_d;
      cur_xlo_q  <= cur_xlo_d;
      cur_tag_q  <= cur_tag_d;
      ovalid_q   <= ovalid_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      otag_q     <= otag_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign arr_x     = arr_x_q;
  assign arr_y     = arr_y_q;
  assign arr_bin   = 4'b0000;
  assign out_valid = ovalid_q;
  assign out_q     = quot_q;
  assign out_r     = rem_q;
  assign out_tag   = otag_q;
  assign out_dbz   = dbz_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural stand-in for the array divider.
module tb_div_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic [3:0] in_y = '0;
  logic [7:0] arr_x;
  logic [3:0] arr_y;
  logic [3:0] arr_bin;
  logic [3:0] arr_q;
  logic [3:0] arr_r;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_q;
  logic [3:0] out_r;
  logic [3:0] out_tag;
  logic       out_dbz;
  logic       out_ovf;
  logic       busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic [3:0] tag;
    logic       dbz;
    logic       ovf;
    int         e;
  } res_t;
  res_t res_q[$];

  div_issue_ctrl #(.SETTLE_CYCLES(2), .FIFO_DEPTH(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .arr_x(arr_x), .arr_y(arr_y), .arr_bin(arr_bin), .arr_q(arr_q), .arr_r(arr_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_tag(out_tag), .out_dbz(out_dbz), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational array divider stand-in
  logic [7:0] div_full, mod_full;
  always_comb begin
    div_full = '0;
    mod_full = '0;
    if (arr_y != 4'd0) begin
      div_full = arr_x / {4'd0, arr_y};
      mod_full = arr_x % {4'd0, arr_y};
    end
    arr_q = div_full[3:0];
    arr_r = mod_full[3:0];
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back('{q: out_q, r: out_r, tag: out_tag, dbz: out_dbz, ovf: out_ovf, e: cyc});
      $display("result edge=%0d q=%0d r=%0d tag=%0d dbz=%0b ovf=%0b",
               cyc, out_q, out_r, out_tag, out_dbz, out_ovf);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and finish 1 time unit after a rising edge.
  task automatic send(input logic [7:0] x, input logic [3:0] y, output int edge_n);
    int budget;
    budget = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    edge_n = -1;
    if (budget >= 200) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      edge_n = cyc;
      $display("accept edge=%0d x=%0d y=%0d", cyc, x, y);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int budget;
    budget = 0;
    while (res_q.size() < n && budget < 400) begin
      @(posedge clk); #1;
      budget++;
    end
    check("result_count", 32'(res_q.size() >= n), 32'd1);
  endtask

  task automatic check_res(input string tag, input int idx, input logic [3:0] q, input logic [3:0] r,
                           input logic [3:0] t, input logic dbz, input logic ovf);
    if (idx < res_q.size()) begin
      check({tag, "_q"},   32'(res_q[idx].q),   32'(q));
      check({tag, "_r"},   32'(res_q[idx].r),   32'(r));
      check({tag, "_tag"}, 32'(res_q[idx].tag), 32'(t));
      check({tag, "_dbz"}, 32'(res_q[idx].dbz), 32'(dbz));
      check({tag, "_ovf"}, 32'(res_q[idx].ovf), 32'(ovf));
    end else begin
      check({tag, "_missing"}, 32'(res_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    res_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, e1, e2, e3;
    logic [7:0] x5;

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_arr_x", 32'(arr_x), 32'd0);
    check("rst_arr_bin", 32'(arr_bin), 32'd0);

    // 1: basic latency and two legal divisions
    send(8'd8, 4'd4, e0);
    wait_results(1);
    check_res("t1a", 0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    if (res_q.size() > 0) check("t1a_latency", 32'(res_q[0].e - e0), 32'd3);
    send(8'd40, 4'd13, e1);
    wait_results(2);
    check_res("t1b", 1, 4'd3, 4'd1, 4'd1, 1'b0, 1'b0);

    // 2: back-to-back legal pairs, 4-cycle result spacing
    do_reset();
    send(8'd7, 4'd3, e0);
    send(8'd5, 4'd5, e1);
    send(8'd17, 4'd5, e2);
    send(8'd15, 4'd3, e3);
    wait_results(4);
    check_res("t2a", 0, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0);
    check_res("t2b", 1, 4'd1, 4'd0, 4'd1, 1'b0, 1'b0);
    check_res("t2c", 2, 4'd3, 4'd2, 4'd2, 1'b0, 1'b0);
    check_res("t2d", 3, 4'd5, 4'd0, 4'd3, 1'b0, 1'b0);
    if (res_q.size() >= 4) begin
      check("t2_gap1", 32'(res_q[1].e - res_q[0].e), 32'd4);
      check("t2_gap2", 32'(res_q[2].e - res_q[1].e), 32'd4);
      check("t2_gap3", 32'(res_q[3].e - res_q[2].e), 32'd4);
    end

    // 3: divide-by-zero and overflow screening
    do_reset();
    send(8'd23, 4'd0, e0);
    wait_results(1);
    check_res("t3_dbz", 0, 4'hF, 4'd7, 4'd0, 1'b1, 1'b0);
    if (res_q.size() > 0) check("t3_dbz_latency", 32'(res_q[0].e - e0), 32'd2);
    check("t3_arr_untouched", 32'(arr_x), 32'd0);
    send(8'd80, 4'd5, e1);
    wait_results(2);
    check_res("t3_ovf", 1, 4'hF, 4'hF, 4'd1, 1'b0, 1'b1);
    send(8'd0, 4'd0, e2);
    wait_results(3);
    check_res("t3_zz", 2, 4'hF, 4'd0, 4'd2, 1'b1, 1'b0);

    // 4: backpressure
    do_reset();
    out_ready = 1'b0;
    send(8'd9, 4'd2, e0);
    send(8'd50, 4'd7, e1);
    send(8'd100, 4'd11, e2);
    in_x = 8'd33;
    in_y = 4'd4;
    in_valid = 1'b1;
    check("t4_full_ready", 32'(in_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_q", 32'({out_q, out_r, out_tag}), 32'h410);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    begin
      int budget;
      budget = 0;
      while (!in_ready && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
      check("t4_ready_returns", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    wait_results(4);
    check_res("t4a", 0, 4'd4, 4'd1, 4'd0, 1'b0, 1'b0);
    check_res("t4b", 1, 4'd7, 4'd1, 4'd1, 1'b0, 1'b0);
    check_res("t4c", 2, 4'd9, 4'd1, 4'd2, 1'b0, 1'b0);
    check_res("t4d", 3, 4'd8, 4'd1, 4'd3, 1'b0, 1'b0);

    // 5: tag wrap over 17 legal pairs
    do_reset();
    for (int i = 0; i < 17; i++) begin
      x5 = 8'(i * 7);
      send(x5, 4'd9, e0);
    end
    wait_results(17);
    for (int i = 0; i < 17; i++) begin
      check_res("t5", i, 4'((i * 7) / 9), 4'((i * 7) % 9), 4'(i % 16), 1'b0, 1'b0);
    end

    // 6: reset in SETTLE with one entry queued
    do_reset();
    send(8'd90, 4'd7, e0);
    send(8'd20, 4'd3, e1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    check("t6_pre_arr_x", 32'(arr_x), 32'd90);
    check("t6_pre_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_arr_x", 32'(arr_x), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_q.delete();
    send(8'd30, 4'd4, e2);
    wait_results(1);
    check_res("t6_after", 0, 4'd7, 4'd2, 4'd0, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("t6_no_stale", 32'(res_q.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
